// File: rtl/lfsr_range_sampler_pkg.sv
// Shared types and defaults for the LFSR range sampler.
// Holds the sampler state encoding and default width/seed constants.
package lfsr_range_sampler_pkg;

    localparam int NUM_BITS_DEF     = 8;
    localparam int SEED_DEFAULT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STEP,
        CHECK,
        OUT
    } state_e;

endpackage

// File: rtl/lfsr_range_sampler_if.sv
// Request/result handshake bundle between game logic and the sampler.
// master: game logic side; slave: sampler side.
interface lfsr_range_sampler_if
    import lfsr_range_sampler_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF
) ();

    logic                i_Req_Valid;
    logic [NUM_BITS-1:0] i_Req_Range;
    logic                o_Req_Ready;
    logic                o_Rand_Valid;
    logic [NUM_BITS-1:0] o_Rand_Data;
    logic                i_Rand_Ready;

    modport master (
        output i_Req_Valid,
        output i_Req_Range,
        output i_Rand_Ready,
        input  o_Req_Ready,
        input  o_Rand_Valid,
        input  o_Rand_Data
    );

    modport slave (
        input  i_Req_Valid,
        input  i_Req_Range,
        input  i_Rand_Ready,
        output o_Req_Ready,
        output o_Rand_Valid,
        output o_Rand_Data
    );

endinterface

// File: rtl/lfsr_range_sampler_rand_mask_gen.sv
// Combinational mask for rejection sampling: smear the MSB of N-1 downward.
// Ports: i_Range (bound N, 0 = full range), o_Mask (all-ones for N=0, 0 for N=1).
module lfsr_range_sampler_rand_mask_gen
    import lfsr_range_sampler_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF
) (
    input  logic [NUM_BITS-1:0] i_Range,
    output logic [NUM_BITS-1:0] o_Mask
);

    logic [NUM_BITS-1:0] n_m1;
    logic                acc;

    // N=0 wraps to all-ones, which is exactly the full-range mask.
    always_comb begin
        n_m1   = i_Range - NUM_BITS'(1);
        acc    = 1'b0;
        o_Mask = '0;
        for (int i = NUM_BITS - 1; i >= 0; i--) begin
            acc       = acc | n_m1[i];
            o_Mask[i] = acc;
        end
    end

endmodule

// File: rtl/lfsr_range_sampler.sv
// Draws unbiased integers in [0,N) from an external LFSR by masked rejection.
// Ports: i_Clk, i_Rst (sync high), i_Seed_Strobe, rif (req/result), LFSR ctrl.
module lfsr_range_sampler
    import lfsr_range_sampler_pkg::*;
#(
    parameter int NUM_BITS     = NUM_BITS_DEF,
    parameter int MAX_TRIES    = 4,
    parameter int SEED_DEFAULT = SEED_DEFAULT_DEF
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Seed_Strobe,
    lfsr_range_sampler_if.slave  rif,
    output logic                 o_LFSR_Enable,
    output logic                 o_Seed_DV,
    output logic [NUM_BITS-1:0]  o_Seed_Data,
    input  logic [NUM_BITS-1:0]  i_LFSR_Data
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [NUM_BITS-1:0] ALL_ONES = '1;
    localparam logic [NUM_BITS-1:0] SEED_DEF_W = NUM_BITS'(SEED_DEFAULT);

    state_e              state_q, state_d;
    logic [NUM_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_BITS-1:0] seed_val_q, seed_val_d;
    logic                seed_pend_q, seed_pend_d;
    logic [NUM_BITS-1:0] range_q, range_d;
    logic [NUM_BITS-1:0] mask_q, mask_d;
    logic [NUM_BITS-1:0] result_q, result_d;
    logic [TW-1:0]       tries_q, tries_d;
    logic [NUM_BITS-1:0] new_mask;
    logic [NUM_BITS-1:0] cand;

    lfsr_range_sampler_rand_mask_gen #(
        .NUM_BITS (NUM_BITS)
    ) u_mask (
        .i_Range (rif.i_Req_Range),
        .o_Mask  (new_mask)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            seed_val_q  <= '0;
            seed_pend_q <= 1'b0;
            range_q     <= '0;
            mask_q      <= '0;
            result_q    <= '0;
            tries_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_val_q  <= seed_val_d;
            seed_pend_q <= seed_pend_d;
            range_q     <= range_d;
            mask_q      <= mask_d;
            result_q    <= result_d;
            tries_q     <= tries_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + NUM_BITS'(1);
        seed_val_d    = seed_val_q;
        seed_pend_d   = seed_pend_q;
        range_d       = range_q;
        mask_d        = mask_q;
        result_d      = result_q;
        tries_d       = tries_q;
        o_LFSR_Enable = 1'b0;
        o_Seed_DV     = 1'b0;
        o_Seed_Data   = '0;
        cand          = i_LFSR_Data & mask_q;

        unique case (state_q)
            IDLE: begin
                if (seed_pend_q) begin
                    state_d = SEED;
                end else if (rif.i_Req_Valid) begin
                    range_d = rif.i_Req_Range;
                    mask_d  = new_mask;
                    tries_d = '0;
                    state_d = STEP;
                end
            end
            SEED: begin
                o_LFSR_Enable = 1'b1;
                o_Seed_DV     = 1'b1;
                o_Seed_Data   = seed_val_q;
                seed_pend_d   = 1'b0;
                state_d       = IDLE;
            end
            STEP: begin
                o_LFSR_Enable = 1'b1;
                state_d       = CHECK;
            end
            CHECK: begin
                if (range_q == '0 || cand < range_q) begin
                    result_d = cand;
                    state_d  = OUT;
                end else if (tries_q == LAST_TRY) begin
                    // cand < 2N here, so one subtraction lands in range
                    result_d = cand - range_q;
                    state_d  = OUT;
                end else begin
                    tries_d = tries_q + TW'(1);
                    state_d = STEP;
                end
            end
            OUT: begin
                if (rif.i_Rand_Ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe overrides any in-flight clear from SEED.
        if (i_Seed_Strobe) begin
            seed_pend_d = 1'b1;
            // all-ones locks up an XNOR LFSR
            seed_val_d  = (cnt_q == ALL_ONES) ? SEED_DEF_W : cnt_q;
        end
    end

    assign rif.o_Req_Ready  = (state_q == IDLE) && !seed_pend_q && !i_Rst;
    assign rif.o_Rand_Valid = (state_q == OUT);
    assign rif.o_Rand_Data  = result_q;

endmodule
